alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that shares the single combinational 4-bit ALU between two requesters.
- Accepts one operation at a time through a valid/ready handshake, with round-robin grant.
- Drives the ALU operands and opcode, holds them stable for an op-dependent number of cycles, then captures the result.
- Returns the result with the requester ID and status flags, and sits between the instruction sources and the ALU.

Parameters:
- DATA_W, 4, operand/result width; must match the ALU.
- OP_W, 4, opcode width.
- LAT_LOGIC, 1, EXEC cycles for opcodes 0000-1001 (≥1).
- LAT_MULDIV, 3, EXEC cycles for opcodes 1010 (mul) and 1011 (div) (≥1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_op  in  OP_W  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above for requester 1.
- alu_a, alu_b  out  DATA_W  ALU operands.
- alu_op  out  OP_W  ALU opcode.
- alu_result  in  DATA_W  ALU combinational result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the op.
- rsp_result  out  DATA_W  captured result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  illegal opcode or divide by zero.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state=IDLE; all outputs 0 except alu_op=4'b1111 (ALU default case, result 0).
  - rr pointer last=1, so requester 0 wins first.
  - Internal latches and counter cleared.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req*_ready is combinational.
  - With a single valid requester, that requester gets ready=1.
  - With both valid, the requester != last gets ready=1.
  - At most one ready is high per cycle.
  - Acceptance occurs on valid & ready.
  - On accept: latch a, b, op, id; set last=id.
  - Illegal op (1100-1111), or op=1011 with b=0: go to RESP with result=0, err=1, no ALU issue.
  - Otherwise go to EXEC with cnt = LAT-1 (LAT selected by op).
- EXEC:
  - alu_a/alu_b/alu_op driven from latched registers for the whole state; ready=0.
  - If cnt==0: capture alu_result into rsp_result, set err=0, go to RESP.
  - Otherwise decrement cnt.
  - With LAT=1, the first EXEC cycle captures.
- RESP:
  - rsp_valid=1; rsp_id/result/zero/err stable until accepted.
  - On rsp_ready: go to IDLE, rsp_valid drops next cycle.
  - While not accepted, hold indefinitely (backpressure); no new accepts.
- Outside EXEC: alu_a=alu_b=0, alu_op=4'b1111.
- rsp_zero is registered alongside rsp_result; for err responses rsp_zero=1.
- Latency, accept to rsp_valid: 1+LAT cycles for legal ops, 1 cycle for err ops. Minimum issue interval is LAT+2 cycles.
- Requests that are valid but not granted are not consumed; the requester must hold its inputs stable.
- Reset mid-operation (any state): immediate return to reset values; in-flight op discarded, no response.
- Width: result is the ALU low DATA_W bits, no overflow flag.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants: OP_NOT=0000, OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR, OP_SHIFT, OP_ADD, OP_SUB, OP_MUL=1010, OP_DIV=1011, OP_IDLE=1111.
  - State enum.
  - Function is_legal_op.
- One sub-module, rr_arb2: 2-way round-robin grant from valid bits and last pointer.

Test Plan:
- Only req0 valid, op=1000, a=3, b=4, alu model correct; rsp_ready=1.
  - req0_ready in cycle 0, alu_op=1000 in cycle 1, rsp_valid in cycle 2 with result=7, id=0, zero=0, err=0.
- Both valid continuously.
  - Grants alternate 0,1,0,1 across 4 ops; the non-granted requester's ready stays 0.
- op=1010, a=2, b=3 with LAT_MULDIV=3.
  - alu inputs stable for exactly 3 cycles; rsp_valid on the 4th cycle after accept; result=6.
- op=1011, b=0; then op=1101.
  - Each gives an rsp_valid one cycle after accept with err=1, result=0, zero=1; alu_op stays 1111.
- rsp_ready=0 for 5 cycles after rsp_valid.
  - Response fields stable; req ready=0 throughout; accept resumes the cycle after rsp_ready=1.
- Assert rst_n=0 mid-EXEC.
  - Outputs return to reset values immediately (async); no response emitted; the next request after release is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, controller states and opcode legality check for the shared ALU
package alu_pkg;

    localparam logic [3:0] OP_NOT   = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_NAND  = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_XNOR  = 4'b0110;
    localparam logic [3:0] OP_SHIFT = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_IDLE  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_DIV;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant from request bits and the last-served pointer
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On contention the requester that was not served last wins.
    assign grant[0] = valid[0] & (~valid[1] | last);
    assign grant[1] = valid[1] & (~valid[0] | ~last);

endmodule

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between two requesters with round-robin grant
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int OP_W       = 4,
    parameter int LAT_LOGIC  = 1,
    parameter int LAT_MULDIV = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    localparam int CNT_W = 8;

    state_t              state, state_nxt;
    logic                last;
    logic [DATA_W-1:0]   lat_a, lat_b;
    logic [OP_W-1:0]     lat_op;
    logic                lat_id;
    logic [CNT_W-1:0]    cnt;
    logic [1:0]          grant;

    logic                accept, acc_id, acc_err;
    logic [DATA_W-1:0]   acc_a, acc_b;
    logic [OP_W-1:0]     acc_op;
    logic [CNT_W-1:0]    acc_cnt;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last),
        .grant (grant)
    );

    assign accept  = (state == ST_IDLE) && (grant != 2'b00);
    assign acc_id  = grant[1];
    assign acc_a   = acc_id ? req1_a  : req0_a;
    assign acc_b   = acc_id ? req1_b  : req0_b;
    assign acc_op  = acc_id ? req1_op : req0_op;
    // Errors short-circuit straight to RESP without touching the ALU.
    assign acc_err = !is_legal_op(4'(acc_op)) ||
                     ((acc_op == OP_W'(OP_DIV)) && (acc_b == '0));
    assign acc_cnt = ((acc_op == OP_W'(OP_MUL)) || (acc_op == OP_W'(OP_DIV)))
                     ? CNT_W'(LAT_MULDIV - 1) : CNT_W'(LAT_LOGIC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = OP_W'(OP_IDLE);
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (accept) state_nxt = acc_err ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: begin
                alu_a  = lat_a;
                alu_b  = lat_b;
                alu_op = lat_op;
                if (cnt == '0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= 1'b1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_op     <= '0;
            lat_id     <= 1'b0;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last   <= acc_id;
                        lat_a  <= acc_a;
                        lat_b  <= acc_b;
                        lat_op <= acc_op;
                        lat_id <= acc_id;
                        cnt    <= acc_cnt;
                        if (acc_err) begin
                            rsp_id     <= acc_id;
                            rsp_result <= '0;
                            rsp_zero   <= 1'b1;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        rsp_id     <= lat_id;
                        rsp_result <= alu_result;
                        rsp_zero   <= (alu_result == '0);
                        rsp_err    <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl against a behavioural model
module tb_alu_share_ctrl;

    localparam int DATA_W     = 4;
    localparam int OP_W       = 4;
    localparam int LAT_LOGIC  = 1;
    localparam int LAT_MULDIV = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic [3:0] alu_a, alu_b, alu_op, alu_result;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [3:0] rsp_result;

    typedef struct {
        logic       id;
        logic [3:0] a, b, op, res;
        logic       zero, err;
        int         acc;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         acc_log[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_acc_cyc = 0;
    int         last_pop_cyc = 0;
    logic       m_last = 1'b1;
    logic [1:0] acc_seen = 2'b00;

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .DATA_W(DATA_W), .OP_W(OP_W), .LAT_LOGIC(LAT_LOGIC), .LAT_MULDIV(LAT_MULDIV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] op);
        logic [3:0] r;
        case (op)
            4'd0:    r = ~a;
            4'd1:    r = a & b;
            4'd2:    r = ~(a & b);
            4'd3:    r = a | b;
            4'd4:    r = ~(a | b);
            4'd5:    r = a ^ b;
            4'd6:    r = ~(a ^ b);
            4'd7:    r = a << 1;
            4'd8:    r = a + b;
            4'd9:    r = a - b;
            4'd10:   r = a * b;
            4'd11:   r = (b == 4'd0) ? 4'd0 : a / b;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    function automatic int lat_of(input logic [3:0] op);
        return (op == 4'd10 || op == 4'd11) ? LAT_MULDIV : LAT_LOGIC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_accept(input logic id, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] op);
        exp_t e;
        e.id   = id;
        e.a    = a;
        e.b    = b;
        e.op   = op;
        e.err  = (op > 4'd11) || (op == 4'd11 && b == 4'd0);
        e.res  = e.err ? 4'd0 : alu_f(a, b, op);
        e.zero = (e.res == 4'd0);
        e.acc  = cyc;
        e.due  = e.err ? cyc + 1 : cyc + 1 + lat_of(op);
        sb.push_back(e);
        m_last       = id;
        acc_seen[id] = 1'b1;
        acc_log.push_back(int'(id));
        last_acc_cyc = cyc;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [1:0] er;
        logic       busy;
        exp_t       e;
        if (rst_n) begin
            busy = (sb.size() != 0);
            er   = 2'b00;
            if (!busy) begin
                if (req0_valid && (!req1_valid || m_last)) er = 2'b01;
                else if (req1_valid)                       er = 2'b10;
            end
            check("ready", 32'({req1_ready, req0_ready}), 32'(er));
            if (busy) e = sb[0];
            if (busy && !e.err && cyc > e.acc && cyc <= e.acc + lat_of(e.op))
                check("alu_drive", 32'({alu_a, alu_b, alu_op}), 32'({e.a, e.b, e.op}));
            else
                check("alu_idle", 32'({alu_a, alu_b, alu_op}), 32'({8'h00, 4'hf}));
            if (busy && cyc >= e.due) begin
                check("rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err}),
                      32'({1'b1, e.id, e.res, e.zero, e.err}));
                if (rsp_valid && rsp_ready) begin
                    void'(sb.pop_front());
                    last_pop_cyc = cyc;
                end
            end else begin
                check("rsp_idle", 32'(rsp_valid), 32'(0));
            end
            if (req0_valid && req0_ready) model_accept(1'b0, req0_a, req0_b, req0_op);
            if (req1_valid && req1_ready) model_accept(1'b1, req1_a, req1_b, req1_op);
        end
    end

    task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] op);
        acc_seen[id] = 1'b0;
        if (id == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int k = 0; k < 80; k++) begin
            @(posedge clk); #1;
            if (acc_seen[id]) break;
        end
        check("issue_accepted", 32'(acc_seen[id]), 32'(1));
        acc_seen[id] = 1'b0;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid,
                         rsp_id, rsp_result, rsp_zero, rsp_err}),
              32'({2'b00, 8'h00, 4'hf, 2'b00, 4'h0, 2'b00}));
    endtask

    initial begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_state");
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 4'd3, 4'd4, 4'b1000);
        drain();

        acc_log.delete();
        fork
            begin
                issue(0, 4'd5, 4'd1, 4'b0101);
                issue(0, 4'd6, 4'd2, 4'b1001);
            end
            begin
                issue(1, 4'd9, 4'd3, 4'b0001);
                issue(1, 4'd4, 4'd4, 4'b1000);
            end
        join
        drain();
        check("alternate_count", 32'(acc_log.size()), 32'(4));
        for (int i = 1; i < acc_log.size(); i++)
            check("alternate", 32'(acc_log[i] != acc_log[i-1]), 32'(1));

        issue(0, 4'd2, 4'd3, 4'b1010);
        drain();
        issue(1, 4'd5, 4'd0, 4'b1011);
        drain();
        issue(0, 4'd7, 4'd2, 4'b1101);
        drain();

        rsp_ready = 1'b0;
        issue(0, 4'd9, 4'd9, 4'b0101);
        fork
            issue(1, 4'd1, 4'd2, 4'b1000);
        join_none
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        repeat (5) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait fork;
        check("resume_after_hs", 32'(last_acc_cyc), 32'(last_pop_cyc + 1));
        drain();

        issue(0, 4'd3, 4'd3, 4'b1010);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        sb.delete();
        m_last = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_held");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        acc_log.delete();
        fork
            issue(1, 4'd2, 4'd2, 4'b1000);
            issue(0, 4'd1, 4'd1, 4'b1000);
        join
        drain();
        check("post_reset_first", 32'(acc_log.size() > 0 ? acc_log[0] : -1), 32'(0));

        acc_seen = 2'b00;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk); #1;
            rsp_ready = ($urandom_range(3) != 0);
            if (acc_seen[0]) begin acc_seen[0] = 1'b0; req0_valid = 1'b0; end
            if (acc_seen[1]) begin acc_seen[1] = 1'b0; req1_valid = 1'b0; end
            if (!req0_valid && $urandom_range(1) == 1) begin
                req0_a = 4'($urandom); req0_b = 4'($urandom);
                req0_op = 4'($urandom_range(15)); req0_valid = 1'b1;
            end
            if (!req1_valid && $urandom_range(1) == 1) begin
                req1_a = 4'($urandom); req1_b = 4'($urandom);
                req1_op = 4'($urandom_range(15)); req1_valid = 1'b1;
            end
        end
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
